// File: rtl/sram_like_arbiter.sv
// Two-master arbiter for a shared SRAM-like port: icache is master 0, dcache is master 1.
// One transfer is outstanding at a time; the granted master's request passes through with zero latency.
module sram_like_arbiter #(
    parameter int RR_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_q, last_d;

    logic any_req, sel, gnt;
    logic in_idle, in_addr, in_data;
    logic addr_ok_fwd, data_ok_fwd;

    always_comb begin
        in_idle = (state_q == IDLE);
        in_addr = (state_q == ADDR);
        in_data = (state_q == DATA);
        any_req = m0_req | m1_req;

        // A lone requester always wins; only a tie is broken by mode.
        if (RR_MODE != 0 && m0_req && m1_req) sel = ~last_q;
        else                                  sel = m1_req;

        gnt = in_idle ? sel : owner_q;
    end

    // Outputs are suppressed during the reset cycle so an in-flight ack is not delivered.
    always_comb begin
        s_req   = ~rst & (in_addr | (in_idle & any_req));
        s_wr    = gnt ? m1_wr    : m0_wr;
        s_size  = gnt ? m1_size  : m0_size;
        s_addr  = gnt ? m1_addr  : m0_addr;
        s_wdata = gnt ? m1_wdata : m0_wdata;

        addr_ok_fwd = s_req & s_addr_ok;
        // data_ok in ADDR only counts when the address is accepted in the same cycle.
        data_ok_fwd = ~rst & s_data_ok & (in_data | (in_addr & s_addr_ok));

        m0_addr_ok = addr_ok_fwd & ~gnt;
        m1_addr_ok = addr_ok_fwd &  gnt;
        m0_data_ok = data_ok_fwd & ~gnt;
        m1_data_ok = data_ok_fwd &  gnt;
        m0_rdata   = s_rdata;
        m1_rdata   = s_rdata;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = sel;
                    state_d = s_addr_ok ? DATA : ADDR;
                end
            end
            ADDR: begin
                if (s_addr_ok) begin
                    if (s_data_ok) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (s_data_ok) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

endmodule
